// File: rtl/int2flt_pkg.sv
// Shared types and constants for the integer-to-binary16 conversion engine.
package int2flt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_LO,
        LD_HI,
        ABS,
        NORM,
        PACK,
        WR_LO,
        WR_HI
    } i2f_state_t;

    localparam int HALF_BIAS = 15;
    localparam int FRAC_W    = 10;
    localparam int EXP_W     = 5;

    // Exponent of a mantissa whose leading one sits in bit 15 with no shifts:
    // 2^15 has biased exponent 15 + 15 = 30.
    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(2 * HALF_BIAS);

    localparam logic [7:0] DEF_IN_ADDR  = 8'd0;
    localparam logic [7:0] DEF_OUT_ADDR = 8'd2;

endpackage

// File: rtl/int2flt_engine_round.sv
// Combinational round-to-nearest-even and pack of a normalized magnitude.
module i2f_round
    import int2flt_pkg::*;
(
    input  logic        sign,
    input  logic [15:0] m,
    input  logic [3:0]  k,
    output logic [15:0] result
);

    logic                guard;
    logic                sticky;
    logic                rnd_up;
    logic [FRAC_W:0]     frac_sum;
    logic [EXP_W-1:0]    exp_base;
    logic [EXP_W-1:0]    exp_fin;
    logic [FRAC_W-1:0]   frac_fin;

    // Round, propagate the mantissa carry into the exponent, then pack.
    // A magnitude without its leading one set is not normalized and packs as +0.
    always_comb begin
        guard    = m[4];
        sticky   = |m[3:0];
        rnd_up   = guard & (sticky | m[5]);
        frac_sum = {1'b0, m[14:5]} + {{FRAC_W{1'b0}}, rnd_up};
        exp_base = EXP_TOP - {1'b0, k};
        exp_fin  = exp_base + {{(EXP_W-1){1'b0}}, frac_sum[FRAC_W]};
        frac_fin = frac_sum[FRAC_W] ? '0 : frac_sum[FRAC_W-1:0];
        result   = {sign, exp_fin, frac_fin};
        if (!m[15]) begin
            result = '0;
        end
    end

endmodule

// File: rtl/int2flt_engine.sv
// Sequential 16-bit signed integer to IEEE-754 binary16 converter working
// in place on the shared data memory with a start/done handshake.
//
// state | meaning
// IDLE  | waiting for start; done holds the last completion
// LD_LO | read integer low byte
// LD_HI | read integer high byte
// ABS   | take magnitude, clear shift count, route zero / normalized / other
// NORM  | shift magnitude left one bit per cycle until its msb is set
// PACK  | round and pack the normalized magnitude
// WR_LO | write result low byte
// WR_HI | write result high byte, raise done
module int2flt_engine
    import int2flt_pkg::*;
#(
    parameter logic [7:0] IN_ADDR  = DEF_IN_ADDR,
    parameter logic [7:0] OUT_ADDR = DEF_OUT_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    i2f_state_t  state;
    i2f_state_t  state_nxt;
    logic [7:0]  x_lo;
    logic [7:0]  x_hi;
    logic [15:0] x_in;
    logic [15:0] m_abs;
    logic        sign;
    logic [15:0] m;
    logic [3:0]  k;
    logic [15:0] result;
    logic [15:0] packed_val;

    assign x_in  = {x_hi, x_lo};
    // Unsigned negate so that -32768 yields 0x8000.
    assign m_abs = x_hi[7] ? (16'd0 - x_in) : x_in;

    i2f_round u_round (
        .sign   (sign),
        .m      (m),
        .k      (k),
        .result (packed_val)
    );

    // State register plus operand, normalization and result datapath.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            done   <= 1'b0;
            x_lo   <= '0;
            x_hi   <= '0;
            sign   <= 1'b0;
            m      <= '0;
            k      <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        done <= 1'b0;
                    end
                end
                LD_LO: x_lo <= mem_rd_data;
                LD_HI: x_hi <= mem_rd_data;
                ABS: begin
                    sign   <= x_hi[7];
                    m      <= m_abs;
                    k      <= '0;
                    result <= '0;
                end
                NORM: begin
                    m <= {m[14:0], 1'b0};
                    k <= k + 4'd1;
                end
                PACK:  result <= packed_val;
                WR_HI: done   <= 1'b1;
                default: ;
            endcase
        end
    end

    // Next-state and memory port decode. Normalization exits are looked ahead
    // (already-normalized skips NORM, NORM leaves on the shift that sets the
    // msb) so NORM lasts exactly k cycles.
    always_comb begin
        state_nxt   = state;
        mem_addr    = IN_ADDR;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LD_LO;
                end
            end
            LD_LO: begin
                mem_addr  = IN_ADDR;
                state_nxt = LD_HI;
            end
            LD_HI: begin
                mem_addr  = IN_ADDR + 8'd1;
                state_nxt = ABS;
            end
            ABS: begin
                if (m_abs == 16'd0) begin
                    state_nxt = WR_LO;
                end else if (m_abs[15]) begin
                    state_nxt = PACK;
                end else begin
                    state_nxt = NORM;
                end
            end
            NORM: begin
                if (m[14]) begin
                    state_nxt = PACK;
                end
            end
            PACK: state_nxt = WR_LO;
            WR_LO: begin
                mem_addr    = OUT_ADDR;
                mem_wr_en   = 1'b1;
                mem_wr_data = result[7:0];
                state_nxt   = WR_HI;
            end
            WR_HI: begin
                mem_addr    = OUT_ADDR + 8'd1;
                mem_wr_en   = 1'b1;
                mem_wr_data = result[15:8];
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/int2flt_engine.md
# int2flt_engine

Sequential integer-to-half-precision converter, the inverse of the float-to-integer program. On a `start` pulse it reads a 16-bit two's-complement integer from data memory and normalizes it iteratively. It rounds to nearest-even and writes the IEEE-754 binary16 result back to data memory, then raises `done`. It sits beside the shared data memory in `top_level` and uses the same start/done handshake as the other conversion engines.

## Interface
- `IN_ADDR`, 8'd0, address of the integer low byte; high byte is at `IN_ADDR+1`.
- `OUT_ADDR`, 8'd2, address of the float low byte; high byte is at `OUT_ADDR+1`.
- `clk` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: synchronous, active-low (0 = reset).
- `start` input 1: request. Sampled only in IDLE.
- `done` output 1: conversion complete. Level, held until the next accepted start.
- `mem_addr` output 8: data-memory address.
- `mem_rd_data` input 8: data-memory read data. Combinational read, valid in the same cycle as `mem_addr`.
- `mem_wr_en` output 1: write strobe. Memory writes on the clock edge.
- `mem_wr_data` output 8: write data.

## Operation
- Integer operand: x = {mem[IN_ADDR+1], mem[IN_ADDR]}.
- Float result: {mem[OUT_ADDR+1], mem[OUT_ADDR]} = {sign, exp[4:0], frac[9:0]}.
- FSM states and transitions:
  - IDLE: on start, go to LD_LO.
  - LD_LO: latch the low byte, go to LD_HI.
  - LD_HI: latch the high byte, go to ABS.
  - ABS: sign = x[15]; m = sign ? -x : x in 16 unsigned bits, so -32768 gives 0x8000. Set k = 0. If m == 0, result = 0x0000 and go to WR_LO; else go to NORM.
  - NORM: while m[15] == 0, shift m left by 1 and increment k, one shift per cycle. When m[15] == 1, go to PACK.
  - PACK: form the rounded result (below), go to WR_LO.
  - WR_LO: write the low result byte, go to WR_HI.
  - WR_HI: write the high result byte; set done; go to IDLE.
- PACK rounding:
  - frac = m[14:5], guard = m[4], sticky = |m[3:0].
  - Round up if guard & (sticky | m[5]).
  - exp = 30 - k.
  - If rounding carries out of frac, then frac = 0 and exp = exp + 1.
  - exp never exceeds 30, so there is no Inf or overflow path.
- The sign bit is kept for all nonzero results. Zero always produces +0 (0x0000).
- Widths: m is 16 bits, k is 4 bits, the frac adder is 11 bits to capture the carry.

## Timing
- Reset values: `done` = 0, `mem_wr_en` = 0, `mem_addr` = IN_ADDR, `mem_wr_data` = 0. State = IDLE.
- Reset mid-operation: the FSM returns to IDLE and no further writes occur. A partially written result is allowed.
- Start acceptance: start is accepted at the edge where the FSM is in IDLE and start = 1. `done` clears at that same edge.
- `start` asserted while not in IDLE is ignored. A start held high across several cycles is accepted once; the FSM re-accepts only in IDLE.
- Latency, counting N from the accept edge:
  - Nonzero input: `done` rises at edge 6+k; k ranges 0..15, so the maximum is 21 (x = ±1).
  - Zero input: `done` rises at edge 5.
- `mem_wr_en` is high only in WR_LO and WR_HI, exactly one cycle each.
- Address/data per state:
  - LD_LO: `mem_addr` = IN_ADDR.
  - LD_HI: `mem_addr` = IN_ADDR+1.
  - WR_LO: `mem_addr` = OUT_ADDR.
  - WR_HI: `mem_addr` = OUT_ADDR+1.
  - `mem_wr_data` in each write state is the corresponding result byte.

## Structure
- Package `int2flt_pkg` holds:
  - the state enum `i2f_state_t` (IDLE, LD_LO, LD_HI, ABS, NORM, PACK, WR_LO, WR_HI);
  - the constants `HALF_BIAS` = 15, `FRAC_W` = 10, `EXP_W` = 5;
  - default addresses.
- One combinational sub-module, `i2f_round`, takes {sign, m, k} and returns the 16-bit packed float. It contains the rounding and exponent carry.
- `int2flt_engine` holds the FSM, the operand and normalization registers, and the memory sequencing.

## Test plan
- Basic values, each started from a fresh IDLE:
  - x = 1 → 0x3C00, `done` at edge 21.
  - x = -1 → 0xBC00.
  - x = 6 → 0x4600.
- Zero: x = 0 → 0x0000, `done` at edge 5. Write strobes occur only at addresses 2 and 3.
- Extremes: x = 32767 → 0x7800 (rounding carries into the exponent). x = -32768 (0x8000) → 0xF800 with k = 0, `done` at edge 6.
- Rounding ties:
  - x = 2049 → 0x6800 (tie, rounds to even, down).
  - x = 2051 → 0x6802 (tie, rounds up).
  - x = 2053 → 0x6802 (tie, rounds to even, down).
- Handshake:
  - Pulse start again while in NORM: it is ignored and the result is unchanged.
  - `done` stays high until the next start, then clears on the accept edge.
  - Back-to-back conversions of x = 1 then x = -1 give 0x3C00 then 0xBC00.
- Reset: drive `reset` = 0 during NORM for x = 1.
  - Next edge: state IDLE, `done` = 0, no write strobes.
  - After releasing reset, x = 1 then converts normally to 0x3C00.
